pl_ex_rns_mc: RTL and testbench
===============================

Name: pl_ex_rns_mc

Overview:
- Parametrised execute stage for the RNS pipeline, placed between IFID and MEMWB.
- Computes integer ops on domain 0 and modular ops on every RNS domain.
- ADD/SUB/AND/OR/NOT/CMP/SHL complete in one cycle; MUL is a multi-cycle iterative modular multiply.
- Multi-cycle MUL adds a ready/valid handshake with upstream stall and a flush path, which the previous single-cycle EX stage lacked.

Parameters:
- NUM_DOMAINS, 2, number of RNS lanes (>=1).
- DATA_WID, 8, lane width in bits.
- MOD_WID, 9, width of each modulus field.
- MODULI, {9'd256, 9'd129}, packed moduli; lane i uses MODULI[i*MOD_WID +: MOD_WID], so lane 0 = 129. Each modulus is in 2..2^DATA_WID.
- PROG_CTR_WID, 10, program counter width.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- in_valid  in  1  IFID presents an op
- in_ready  out  1  stage can accept (low while MUL busy)
- flush  in  1  kill in-flight and accepted op (branch taken)
- alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 MUL, 6 CMP, 7 SHL
- rns_op  in  1  1 = modular op on all lanes; 0 = integer op on lane 0
- op1, op2  in  NUM_DOMAINS*DATA_WID  lane-packed operands, lane 0 in LSBs
- res_addr  in  4  {rns_file, reg[2:0]}, passed through
- pred_nxt_prog_ctr  in  PROG_CTR_WID  passed through
- out_valid  out  1  result registered and valid
- operation_result  out  NUM_DOMAINS*DATA_WID  result
- destination_reg_addr  out  4  registered res_addr
- pred_nxt_prog_ctr_EX  out  PROG_CTR_WID  registered PC
- branch_conds_EX  out  5  {gt, lt, eq, cout, cmp_valid}

Behaviour:
- Reset (async): all outputs 0, state IDLE, in_ready = 0 while reset is asserted and 1 after release.
- States:
  - IDLE: in_ready = 1. On in_valid & !flush: non-MUL op loads the output registers next edge with out_valid = 1. MUL loads lane accumulators = 0, bit counter = DATA_WID-1, latches operands/addr/PC, goes to BUSY, out_valid = 0.
  - BUSY: in_ready = 0. Each cycle every lane does acc = (2*acc + (op1 bit k ? op2 : 0)) mod m_i, op1 consumed MSB first. The reduction uses two conditional subtracts (input < 3m). After the k = 0 step, go to DONE.
  - DONE: operation_result = acc lanes, out_valid = 1 for one cycle, return to IDLE with in_ready = 1. An input arriving while in DONE is not accepted.
- MUL latency: accept edge, then DATA_WID compute edges, then 1 result edge. out_valid rises DATA_WID+1 cycles after acceptance.
- out_valid is a one-cycle pulse per accepted op; no output backpressure.
- RNS arithmetic, per lane mod m_i:
  - ADD = (a+b) mod m; SUB = a-b, adding m if negative.
  - AND/OR/NOT are bitwise, then reduced mod m.
  - SHL = 2a mod m.
  - Operands are treated as already < m.
- Integer mode: lane 0 only; upper lanes output 0.
  - ADD/SHL produce DATA_WID-bit result with cout = carry out.
  - SUB is two's complement.
  - MUL returns the low DATA_WID bits; its cout = 1 if the high product bits are nonzero, computed through the same iterative path with modulus 2^DATA_WID plus a sticky overflow bit.
- CMP: integer lane 0, unsigned. Sets gt/lt/eq and cmp_valid = 1; operation_result = 0. All other ops give gt/lt/eq/cmp_valid = 0.
- cout is 0 in RNS mode.
- Flush: synchronous. In IDLE it blocks acceptance that cycle. In BUSY/DONE it returns to IDLE; next out_valid = 0 and no result is produced.
- Flush has priority over in_valid. Reset mid-MUL aborts immediately.

Optional Feature:
- EX_STALL_CNT_EN: adds output stall_cycles[15:0], counting cycles with in_valid & !in_ready. It saturates at 16'hFFFF and is cleared by reset. Without the macro the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package pl_rns_pkg: alu_op encodings, branch_conds bit indices, default MODULI, and a mod-reduce-by-conditional-subtract function.
- Sub-module pl_modmul_iter: one per lane, holding the accumulator plus the step datapath, driven by a shared counter/FSM in the parent.

Test Plan:
- RNS ADD, op1 = {8'd200, 8'd100}, op2 = {8'd100, 8'd50} -> next cycle result {8'd44, 8'd21}, out_valid = 1, cout = 0.
- RNS MUL, op1 = {8'd200, 8'd100}, op2 = {8'd3, 8'd50} -> in_ready low for 9 cycles; out_valid at acceptance+9 with {8'd88, 8'd98}.
- Integer ADD 200+100 -> lane 0 = 44, branch_conds_EX = 5'b00011 is wrong; expected {0, 0, 0, 1, 0}. Integer CMP 5 vs 9 -> {0, 1, 0, 0, 1}.
- flush asserted 3 cycles into a MUL -> no out_valid, in_ready = 1 next cycle; a following ADD completes normally.
- reset asserted mid-MUL, asynchronous to clk -> all outputs 0 immediately, state IDLE after release.
- RNS SUB lane 0, 10-20 with m = 129 -> 119; with EX_STALL_CNT_EN, hold in_valid during a MUL -> stall_cycles = 9.

Source files
------------

// File: rtl/pl_rns_pkg.sv
// Shared encodings and helpers for the RNS execute stage.
// Modular reduction here assumes the input is below three times the modulus.
package pl_rns_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  localparam int BC_CMPV = 0;
  localparam int BC_COUT = 1;
  localparam int BC_EQ   = 2;
  localparam int BC_LT   = 3;
  localparam int BC_GT   = 4;

  localparam logic [17:0] DEF_MODULI = {9'd256, 9'd129};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } ex_state_t;

  function automatic logic [31:0] mod_reduce(
    input logic [31:0] x,
    input logic [31:0] m
  );
    logic [31:0] r;
    r = x;
    if (r >= m) r = r - m;
    if (r >= m) r = r - m;
    return r;
  endfunction

endpackage

// File: rtl/pl_ex_rns_mc_modmul.sv
// One lane of the iterative modular multiplier: acc = (2*acc + bit*mcand) mod m.
// wrap flags that the step needed reduction (used as integer overflow).
module pl_modmul_iter
  import pl_rns_pkg::*;
#(
  parameter int DATA_WID = 8,
  parameter int MOD_WID  = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                step,
  input  logic                bit_k,
  input  logic [DATA_WID-1:0] mcand,
  input  logic [MOD_WID-1:0]  modulus,
  output logic [DATA_WID-1:0] acc,
  output logic                wrap
);

  logic [31:0] sum;
  logic [31:0] red;
  logic        unused_red;

  always_comb begin
    sum  = (32'(acc) << 1) + (bit_k ? 32'(mcand) : 32'd0);
    red  = mod_reduce(sum, 32'(modulus));
    wrap = (sum >= 32'(modulus));
  end

  assign unused_red = ^red[31:DATA_WID];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (step) acc <= red[DATA_WID-1:0];
  end

endmodule

// File: rtl/pl_ex_rns_mc.sv
// RNS execute stage: single-cycle ALU ops plus an iterative modular MUL.
// Optional EX_STALL_CNT_EN adds a saturating stall_cycles counter.
module pl_ex_rns_mc
  import pl_rns_pkg::*;
#(
  parameter int NUM_DOMAINS  = 2,
  parameter int DATA_WID     = 8,
  parameter int MOD_WID      = 9,
  parameter logic [NUM_DOMAINS*MOD_WID-1:0] MODULI = DEF_MODULI,
  parameter int PROG_CTR_WID = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  input  logic [2:0]                      alu_op,
  input  logic                            rns_op,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op1,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op2,
  input  logic [3:0]                      res_addr,
  input  logic [PROG_CTR_WID-1:0]         pred_nxt_prog_ctr,
  output logic                            out_valid,
  output logic [NUM_DOMAINS*DATA_WID-1:0] operation_result,
  output logic [3:0]                      destination_reg_addr,
  output logic [PROG_CTR_WID-1:0]         pred_nxt_prog_ctr_EX,
  output logic [4:0]                      branch_conds_EX
`ifdef EX_STALL_CNT_EN
  ,
  output logic [15:0]                     stall_cycles
`endif
);

  localparam int W  = NUM_DOMAINS * DATA_WID;
  localparam int CW = (DATA_WID > 1) ? $clog2(DATA_WID) : 1;
  localparam logic [MOD_WID-1:0] INT_MOD = MOD_WID'(2 ** DATA_WID);
  localparam logic [W-1:0] L0_MASK = W'({DATA_WID{1'b1}});

  ex_state_t state, state_d;
  logic take_fast, take_mul, step, emit;

  logic [CW-1:0]           cnt;
  logic [W-1:0]            op1_q, op2_q;
  logic                    rns_q, ovf;
  logic [3:0]              addr_q;
  logic [PROG_CTR_WID-1:0] pc_q;

  // Single-cycle RNS lanes
  logic [W-1:0] rns_res;
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_lane
    localparam logic [31:0] M = 32'(MODULI[i*MOD_WID +: MOD_WID]);
    logic [31:0]         a, b, r;
    logic [DATA_WID-1:0] na;
    logic                unused_r;
    always_comb begin
      a  = 32'(op1[i*DATA_WID +: DATA_WID]);
      b  = 32'(op2[i*DATA_WID +: DATA_WID]);
      na = ~op1[i*DATA_WID +: DATA_WID];
      r  = '0;
      unique case (alu_op)
        OP_ADD:  r = mod_reduce(a + b, M);
        OP_SUB:  r = (a >= b) ? a - b : a + M - b;
        OP_AND:  r = (a & b) % M;
        OP_OR:   r = (a | b) % M;
        OP_NOT:  r = 32'(na) % M;
        OP_SHL:  r = mod_reduce(a << 1, M);
        default: r = '0;
      endcase
    end
    assign rns_res[i*DATA_WID +: DATA_WID] = r[DATA_WID-1:0];
    assign unused_r = ^r[31:DATA_WID];
  end

  // Integer path on lane 0
  logic [DATA_WID-1:0] a0, b0, int_res;
  logic                int_cout, is_cmp;
  always_comb begin
    a0       = op1[DATA_WID-1:0];
    b0       = op2[DATA_WID-1:0];
    int_res  = '0;
    int_cout = 1'b0;
    unique case (alu_op)
      OP_ADD:  {int_cout, int_res} = {1'b0, a0} + {1'b0, b0};
      OP_SUB:  int_res = a0 - b0;
      OP_AND:  int_res = a0 & b0;
      OP_OR:   int_res = a0 | b0;
      OP_NOT:  int_res = ~a0;
      OP_SHL:  {int_cout, int_res} = {a0, 1'b0};
      default: int_res = '0;
    endcase
  end

  assign is_cmp = (alu_op == OP_CMP);

  logic [W-1:0] fast_res;
  logic [4:0]   fast_conds;
  always_comb begin
    fast_res = rns_op ? rns_res : W'(int_res);
    if (is_cmp) fast_res = '0;
    fast_conds          = '0;
    fast_conds[BC_GT]   = is_cmp && (a0 > b0);
    fast_conds[BC_LT]   = is_cmp && (a0 < b0);
    fast_conds[BC_EQ]   = is_cmp && (a0 == b0);
    fast_conds[BC_COUT] = !is_cmp && !rns_op && int_cout;
    fast_conds[BC_CMPV] = is_cmp;
  end

  // Iterative multiplier lanes
  logic [W-1:0]           acc_all;
  logic [NUM_DOMAINS-1:0] wrap;
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_mul
    localparam logic [MOD_WID-1:0] LM = MODULI[i*MOD_WID +: MOD_WID];
    logic [DATA_WID-1:0] a_l;
    assign a_l = op1_q[i*DATA_WID +: DATA_WID];
    pl_modmul_iter #(
      .DATA_WID(DATA_WID),
      .MOD_WID (MOD_WID)
    ) u_mm (
      .clk    (clk),
      .rst    (reset),
      .clr    (take_mul),
      .step   (step),
      .bit_k  (a_l[cnt]),
      .mcand  (op2_q[i*DATA_WID +: DATA_WID]),
      .modulus(rns_q ? LM : INT_MOD),
      .acc    (acc_all[i*DATA_WID +: DATA_WID]),
      .wrap   (wrap[i])
    );
  end

  logic [W-1:0] mul_res;
  logic [4:0]   mul_conds;
  always_comb begin
    mul_res            = rns_q ? acc_all : (acc_all & L0_MASK);
    mul_conds          = '0;
    mul_conds[BC_COUT] = !rns_q && ovf;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    take_fast = 1'b0;
    take_mul  = 1'b0;
    step      = 1'b0;
    emit      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = !reset;
        if (in_valid && !flush) begin
          if (alu_op == OP_MUL) begin
            take_mul = 1'b1;
            state_d  = S_BUSY;
          end else begin
            take_fast = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        emit    = !flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      rns_q  <= 1'b0;
      ovf    <= 1'b0;
      addr_q <= '0;
      pc_q   <= '0;
    end else begin
      state <= state_d;
      if (take_mul) begin
        cnt    <= CW'(DATA_WID - 1);
        op1_q  <= op1;
        op2_q  <= op2;
        rns_q  <= rns_op;
        ovf    <= 1'b0;
        addr_q <= res_addr;
        pc_q   <= pred_nxt_prog_ctr;
      end else if (step) begin
        cnt <= cnt - 1'b1;
        ovf <= ovf | wrap[0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid            <= 1'b0;
      operation_result     <= '0;
      destination_reg_addr <= '0;
      pred_nxt_prog_ctr_EX <= '0;
      branch_conds_EX      <= '0;
    end else if (take_fast) begin
      out_valid            <= 1'b1;
      operation_result     <= fast_res;
      destination_reg_addr <= res_addr;
      pred_nxt_prog_ctr_EX <= pred_nxt_prog_ctr;
      branch_conds_EX      <= fast_conds;
    end else if (emit) begin
      out_valid            <= 1'b1;
      operation_result     <= mul_res;
      destination_reg_addr <= addr_q;
      pred_nxt_prog_ctr_EX <= pc_q;
      branch_conds_EX      <= mul_conds;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef EX_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cycles <= '0;
    else if (in_valid && !in_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pl_ex_rns_mc.sv
// Scoreboard bench for pl_ex_rns_mc with directed vectors.
// Expected responses are queued at issue; a negedge monitor compares.
module tb_pl_ex_rns_mc;
  import pl_rns_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         rns_op = 1'b0;
  logic [2:0]   alu_op = 3'd0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [3:0]   res_addr = '0;
  logic [9:0]   pc = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] operation_result;
  logic [3:0]   destination_reg_addr;
  logic [9:0]   pred_nxt_prog_ctr_EX;
  logic [4:0]   branch_conds_EX;
`ifdef EX_STALL_CNT_EN
  logic [15:0]  stall_cycles;
`endif

  pl_ex_rns_mc dut (
    .clk                 (clk),
    .reset               (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .flush               (flush),
    .alu_op              (alu_op),
    .rns_op              (rns_op),
    .op1                 (op1),
    .op2                 (op2),
    .res_addr            (res_addr),
    .pred_nxt_prog_ctr   (pc),
    .out_valid           (out_valid),
    .operation_result    (operation_result),
    .destination_reg_addr(destination_reg_addr),
    .pred_nxt_prog_ctr_EX(pred_nxt_prog_ctr_EX),
    .branch_conds_EX     (branch_conds_EX)
`ifdef EX_STALL_CNT_EN
    ,
    .stall_cycles        (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   addr;
    logic [9:0]   pc;
    logic [4:0]   conds;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("out_valid_unexpected", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", 32'(operation_result), 32'(e.res));
        chk("dest_addr", 32'(destination_reg_addr), 32'(e.addr));
        chk("pc", 32'(pred_nxt_prog_ctr_EX), 32'(e.pc));
        chk("branch_conds", 32'(branch_conds_EX), 32'(e.conds));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic rns,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [4:0] ec,
                       input bit expect_out);
    int   n;
    exp_t e;
    tag++;
    alu_op   = op;
    rns_op   = rns;
    op1      = a;
    op2      = b;
    res_addr = 4'(tag);
    pc       = 10'(tag * 7 + 3);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'(in_ready), 32'd1);
    if (expect_out) begin
      e.res   = er;
      e.addr  = res_addr;
      e.pc    = pc;
      e.conds = ec;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic mul_wait(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'd9);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(operation_result), 32'd0);
    chk("rst_conds", 32'(branch_conds_EX), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    issue(OP_ADD, 1, {8'd200, 8'd100}, {8'd100, 8'd50}, {8'd44, 8'd21}, 5'b00000, 1);
    issue(OP_ADD, 0, {8'd0, 8'd200}, {8'd0, 8'd100}, 16'd44, 5'b00010, 1);
    issue(OP_CMP, 0, {8'd0, 8'd5}, {8'd0, 8'd9}, 16'd0, 5'b01001, 1);
    issue(OP_CMP, 0, {8'd3, 8'd9}, {8'd0, 8'd9}, 16'd0, 5'b00101, 1);
    issue(OP_CMP, 1, {8'd0, 8'd200}, {8'd0, 8'd7}, 16'd0, 5'b10001, 1);
    issue(OP_SUB, 1, {8'd30, 8'd10}, {8'd10, 8'd20}, {8'd20, 8'd119}, 5'b00000, 1);
    issue(OP_SUB, 0, {8'd0, 8'd10}, {8'd0, 8'd20}, 16'd246, 5'b00000, 1);
    issue(OP_AND, 1, {8'hFF, 8'd120}, {8'h3C, 8'd100}, {8'd60, 8'd96}, 5'b00000, 1);
    issue(OP_OR, 1, {8'hF0, 8'h80}, {8'h0F, 8'h05}, {8'd255, 8'd4}, 5'b00000, 1);
    issue(OP_NOT, 1, {8'd15, 8'd3}, 16'd0, {8'd240, 8'd123}, 5'b00000, 1);
    issue(OP_SHL, 1, {8'd200, 8'd100}, 16'd0, {8'd144, 8'd71}, 5'b00000, 1);
    issue(OP_SHL, 0, {8'd0, 8'h81}, 16'd0, 16'h0002, 5'b00010, 1);
    drain();

    issue(OP_MUL, 1, {8'd200, 8'd100}, {8'd3, 8'd50}, {8'd88, 8'd98}, 5'b00000, 1);
    mul_wait("mul_rns");
    issue(OP_MUL, 1, {8'd255, 8'd128}, {8'd255, 8'd128}, {8'd1, 8'd1}, 5'b00000, 1);
    mul_wait("mul_rns_edge");
    issue(OP_MUL, 0, {8'd7, 8'd20}, {8'd9, 8'd13}, 16'd4, 5'b00010, 1);
    mul_wait("mul_int_ovf");
    issue(OP_MUL, 0, {8'd7, 8'd15}, {8'd9, 8'd17}, 16'd255, 5'b00000, 1);
    mul_wait("mul_int_max");
    drain();

    issue(OP_MUL, 1, {8'd9, 8'd9}, {8'd9, 8'd9}, 16'd0, 5'b00000, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_no_valid", 32'(out_valid), 32'd0);
    issue(OP_ADD, 1, {8'd1, 8'd2}, {8'd3, 8'd4}, {8'd4, 8'd6}, 5'b00000, 1);
    drain();

    alu_op   = OP_ADD;
    rns_op   = 1'b1;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_blocks", 32'(out_valid), 32'd0);

    issue(OP_ADD, 1, {8'd5, 8'd6}, {8'd7, 8'd8}, {8'd12, 8'd14}, 5'b00000, 1);
    drain();
    issue(OP_MUL, 1, {8'd9, 8'd9}, {8'd9, 8'd9}, 16'd0, 5'b00000, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midmul_rst_result", 32'(operation_result), 32'd0);
    chk("midmul_rst_pc", 32'(pred_nxt_prog_ctr_EX), 32'd0);
    chk("midmul_rst_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midmul_rst_idle", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    issue(OP_SUB, 1, {8'd0, 8'd10}, {8'd0, 8'd20}, {8'd0, 8'd119}, 5'b00000, 1);
    drain();

`ifdef EX_STALL_CNT_EN
    chk("stall_cnt_zero", 32'(stall_cycles), 32'd0);
    issue(OP_MUL, 1, {8'd200, 8'd100}, {8'd3, 8'd50}, {8'd88, 8'd98}, 5'b00000, 1);
    issue(OP_ADD, 1, {8'd200, 8'd100}, {8'd100, 8'd50}, {8'd44, 8'd21}, 5'b00000, 1);
    chk("stall_cycles", 32'(stall_cycles), 32'd9);
    drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
